// File: rtl/mtr_ramp_ctrl_if.sv
// Bundle of signals between the command source / PWM timer side and the
// ramp controller for one motor channel.
//   master : drives the command, brake and period-start pulse
//   slave  : the ramp controller, returns duty, direction and busy
interface mtr_ramp_ctrl_if;
  logic        cmd_vld;
  logic [10:0] cmd;
  logic        brake;
  logic        prd_strt;
  logic [9:0]  duty;
  logic        rev;
  logic        busy;

  modport master (
    output cmd_vld,
    output cmd,
    output brake,
    output prd_strt,
    input  duty,
    input  rev,
    input  busy
  );

  modport slave (
    input  cmd_vld,
    input  cmd,
    input  brake,
    input  prd_strt,
    output duty,
    output rev,
    output busy
  );
endinterface

// File: rtl/mtr_ramp_ctrl.sv
// Slew-limited duty scheduler for one motor channel.
// Turns a signed 11-bit drive command into a 10-bit duty magnitude plus a
// direction bit, stepping duty by STEP once per PWM period (on prd_strt only).
// A direction reversal first decelerates duty to zero; brake forces zero at once.
// Optional build macro MTR_DEADTIME_EN adds a DEAD state that holds duty at
// zero for DEAD_PRDS PWM periods between deceleration and the new direction.
module mtr_ramp_ctrl #(
  parameter int unsigned STEP      = 8,
  parameter int unsigned DEAD_PRDS = 4
) (
  input logic            clk,
  input logic            rst_n,
  mtr_ramp_ctrl_if.slave bus
);

  localparam logic [10:0] STEP_W = 11'(STEP);
  localparam bit CFG_OK = (STEP >= 1) && (STEP <= 1023) &&
                          (DEAD_PRDS >= 1) && (DEAD_PRDS <= 255);

  // Reject out-of-range parameters at elaboration time.
  if (!CFG_OK) begin : g_bad_cfg
    $error("mtr_ramp_ctrl: STEP must be 1..1023 and DEAD_PRDS 1..255");
  end

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RAMP  = 3'd1,
    ST_DECEL = 3'd2,
    ST_BRAKE = 3'd3
`ifdef MTR_DEADTIME_EN
    ,
    ST_DEAD  = 3'd4
`endif
  } state_t;

  // State entered when deceleration reaches zero duty.
`ifdef MTR_DEADTIME_EN
  localparam state_t ST_ZERO    = ST_DEAD;
  localparam logic [7:0] DEAD_LAST = 8'(DEAD_PRDS - 1);
`else
  localparam state_t ST_ZERO    = ST_IDLE;
`endif

  // |cmd|, with the single unrepresentable value -1024 saturated to 1023.
  function automatic logic [9:0] cmd_mag(input logic [10:0] c);
    logic [10:0] neg;
    neg = ~c + 11'd1;
    if (c == 11'h400) begin
      cmd_mag = 10'd1023;
    end else if (c[10]) begin
      cmd_mag = neg[9:0];
    end else begin
      cmd_mag = c[9:0];
    end
  endfunction

  // min(d + STEP, t), 11 bits wide so the sum can never wrap.
  function automatic logic [9:0] step_up(input logic [9:0] d, input logic [9:0] t);
    logic [10:0] sum;
    sum = {1'b0, d} + STEP_W;
    if (sum > {1'b0, t}) begin
      step_up = t;
    end else begin
      step_up = sum[9:0];
    end
  endfunction

  // max(d - STEP, t), signed so the floor (t >= 0) also clamps underflow.
  function automatic logic [9:0] step_dn(input logic [9:0] d, input logic [9:0] t);
    logic signed [11:0] diff;
    diff = $signed({2'b00, d}) - $signed({1'b0, STEP_W});
    if (diff < $signed({2'b00, t})) begin
      step_dn = t;
    end else begin
      step_dn = diff[9:0];
    end
  endfunction

  // One ramp step of d toward t; equal means hold.
  function automatic logic [9:0] move_toward(input logic [9:0] d, input logic [9:0] t);
    if (d < t) begin
      move_toward = step_up(d, t);
    end else if (d > t) begin
      move_toward = step_dn(d, t);
    end else begin
      move_toward = d;
    end
  endfunction

  state_t      state_q, state_d;
  logic [9:0]  duty_q, duty_d;
  logic        rev_q, rev_d;
  logic        busy_q, busy_d;
  logic [9:0]  tgt_mag_q, tgt_mag_d;
  logic        tgt_rev_q, tgt_rev_d;
  logic [9:0]  toward_s;
  logic [9:0]  dec_s;
`ifdef MTR_DEADTIME_EN
  logic [7:0]  dead_cnt_q, dead_cnt_d;
`endif

  assign toward_s = move_toward(duty_q, tgt_mag_q);
  assign dec_s    = step_dn(duty_q, 10'd0);

  // Next-state, duty/direction update and target capture.
  always_comb begin
    state_d   = state_q;
    duty_d    = duty_q;
    rev_d     = rev_q;
    tgt_mag_d = tgt_mag_q;
    tgt_rev_d = tgt_rev_q;
`ifdef MTR_DEADTIME_EN
    dead_cnt_d = dead_cnt_q;
`endif

    if (bus.brake) begin
      // Brake wins over everything, no prd_strt needed; rev is held.
      state_d   = ST_BRAKE;
      duty_d    = 10'd0;
      tgt_mag_d = 10'd0;
`ifdef MTR_DEADTIME_EN
      dead_cnt_d = 8'd0;
`endif
    end else begin
      // Steps use the target held before any same-cycle cmd_vld.
      case (state_q)
        ST_IDLE: begin
          if (bus.prd_strt && (tgt_mag_q != 10'd0)) begin
            rev_d   = tgt_rev_q;
            duty_d  = step_up(10'd0, tgt_mag_q);
            state_d = ST_RAMP;
          end else begin
            duty_d  = 10'd0;
          end
        end
        ST_RAMP: begin
          if (bus.prd_strt) begin
            if ((tgt_rev_q != rev_q) && (duty_q != 10'd0)) begin
              duty_d  = dec_s;
              state_d = (dec_s == 10'd0) ? ST_ZERO : ST_DECEL;
            end else begin
              duty_d  = toward_s;
              state_d = ((toward_s == 10'd0) && (tgt_mag_q == 10'd0)) ? ST_IDLE : ST_RAMP;
            end
          end else begin
            state_d = ST_RAMP;
          end
        end
        ST_DECEL: begin
          if (bus.prd_strt) begin
            if ((tgt_rev_q == rev_q) && (tgt_mag_q != 10'd0)) begin
              duty_d  = toward_s;
              state_d = ST_RAMP;
            end else begin
              duty_d  = dec_s;
              state_d = (dec_s == 10'd0) ? ST_ZERO : ST_DECEL;
            end
          end else begin
            state_d = ST_DECEL;
          end
        end
`ifdef MTR_DEADTIME_EN
        ST_DEAD: begin
          duty_d = 10'd0;
          if (bus.prd_strt) begin
            if (dead_cnt_q == DEAD_LAST) begin
              dead_cnt_d = 8'd0;
              state_d    = ST_IDLE;
            end else begin
              dead_cnt_d = dead_cnt_q + 8'd1;
            end
          end else begin
            dead_cnt_d = dead_cnt_q;
          end
        end
`endif
        ST_BRAKE: begin
          // Release: forget the old target; motion needs a fresh command.
          state_d   = ST_IDLE;
          duty_d    = 10'd0;
          tgt_mag_d = 10'd0;
        end
        default: begin
          state_d = ST_IDLE;
          duty_d  = 10'd0;
        end
      endcase

      if (bus.cmd_vld) begin
        if (bus.cmd == 11'd0) begin
          tgt_mag_d = 10'd0;
        end else begin
          tgt_mag_d = cmd_mag(bus.cmd);
          tgt_rev_d = bus.cmd[10];
        end
      end else begin
        tgt_rev_d = tgt_rev_d;
      end
    end

    busy_d = !((state_d == ST_IDLE) ||
               ((state_d == ST_RAMP) && (duty_d == tgt_mag_d) && (rev_d == tgt_rev_d)));
  end

  // State, target and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      duty_q    <= 10'd0;
      rev_q     <= 1'b0;
      busy_q    <= 1'b0;
      tgt_mag_q <= 10'd0;
      tgt_rev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      duty_q    <= duty_d;
      rev_q     <= rev_d;
      busy_q    <= busy_d;
      tgt_mag_q <= tgt_mag_d;
      tgt_rev_q <= tgt_rev_d;
    end
  end

`ifdef MTR_DEADTIME_EN
  // Dead-time period counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dead_cnt_q <= 8'd0;
    end else begin
      dead_cnt_q <= dead_cnt_d;
    end
  end
`endif

  assign bus.duty = duty_q;
  assign bus.rev  = rev_q;
  assign bus.busy = busy_q;

endmodule

// File: doc/mtr_ramp_ctrl.md
Name: mtr_ramp_ctrl

Overview:
- Slew-limited duty scheduler for one motor channel. Sits between the command source and the 10-bit PWM generator.
- Converts a signed drive command into a 10-bit duty magnitude plus a direction bit.
- Ramps duty by a fixed step once per PWM period, changing it only at period boundaries.
- Forces duty to zero, with optional dead time, before any direction reversal. Brake input overrides everything.

Parameters:
- STEP, 8: duty change applied per PWM period (1..1023).
- DEAD_PRDS, 4: zero-duty PWM periods inserted on reversal (used only with MTR_DEADTIME_EN; 1..255).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cmd_vld  in  1  one-cycle strobe; loads cmd as the new target.
- cmd  in  11  signed two's-complement drive command.
- brake  in  1  level; forces duty to 0 while high.
- prd_strt  in  1  one-cycle pulse at each PWM counter wrap (count 1023 to 0).
- duty  out  10  duty to the PWM generator; registered.
- rev  out  1  direction: 0 forward, 1 reverse; registered.
- busy  out  1  high while the block has not reached its target.

Behaviour:
- Clock and reset: single clock clk; rst_n asynchronous active-low. Reset gives duty=0, rev=0, busy=0, state IDLE, tgt_mag=0, tgt_rev=0.
- Target load (cmd_vld=1, brake=0):
  - tgt_rev=cmd[10]; tgt_mag=|cmd|.
  - cmd=-1024 saturates to tgt_mag=1023.
  - cmd=0 gives tgt_mag=0 and leaves tgt_rev unchanged.
  - Latest command wins; no backpressure.
- Step rule: all duty/rev updates in IDLE, RAMP, DECEL and DEAD occur only on a clk edge where prd_strt=1. The new value is visible the cycle after prd_strt. If cmd_vld and prd_strt fire in the same cycle, the step uses the old target.
- Arithmetic:
  - up = min(duty+STEP, tgt_mag), computed 11 bits wide, so no wrap.
  - down = max(duty-STEP, tgt_mag), computed signed, floored at 0.
- States:
  - IDLE (duty=0): on prd_strt with tgt_mag!=0, set rev=tgt_rev, duty=min(STEP, tgt_mag), go to RAMP.
  - RAMP:
    - On prd_strt with tgt_rev!=rev and duty!=0, go to DECEL; duty steps toward 0 in the same update.
    - Otherwise apply up or down toward tgt_mag.
    - If the result is 0 and tgt_mag=0, go to IDLE.
    - duty==tgt_mag means hold.
  - DECEL: on prd_strt, duty=max(duty-STEP, 0). When duty becomes 0, go to DEAD (macro on) or IDLE (macro off). Retargeting to the original direction during DECEL returns to RAMP on the next prd_strt.
  - DEAD: counts DEAD_PRDS prd_strt pulses with duty=0, then goes to IDLE. rev stays unchanged until IDLE reloads it.
  - BRAKE:
    - brake=1 takes priority in any state. Duty is forced to 0 on the next clk edge without waiting for prd_strt; rev is held.
    - Stay in BRAKE while brake=1; cmd_vld is ignored.
    - On release, tgt_mag=0 and the state goes to IDLE; motion resumes only on a new cmd_vld.
- busy=1 in all states except IDLE, and except RAMP with duty==tgt_mag and rev==tgt_rev. busy=1 in BRAKE.
- Invariant: rev never changes while duty!=0.

Optional Feature:
- Macro MTR_DEADTIME_EN.
- Defined: DEAD state is present; a reversal holds duty=0 for DEAD_PRDS full PWM periods before the new direction is driven.
- Undefined: DEAD state and its counter are not built. DECEL goes directly to IDLE, so rev flips on the first prd_strt after duty reaches 0.

Test Plan:
1. Reset, cmd=+100, STEP=8, prd_strt every 1024 clks -> duty 8,16,...,96,100 on successive periods. busy drops the cycle duty=100; rev=0 throughout.
2. Hold at duty 1020, cmd=+1023 -> next period duty=1023, no wrap. cmd=-1024 then gives tgt_mag=1023, tgt_rev=1.
3. duty=40 fwd, cmd=-24, macro on -> duty 32,24,16,8,0, then 4 periods at 0 with rev=0, then rev=1 with duty 8,16,24. Macro off -> rev=1 on the first prd_strt after 0.
4. duty=500, brake=1 mid-period -> duty=0 next clk with no prd_strt. brake=0 -> duty stays 0 and busy=0 until a new cmd_vld.
5. cmd_vld(+200) coincident with prd_strt at duty 16 toward 64 -> duty=24 (old target honoured), ramp continues to 200.
6. rst_n low mid-ramp at duty 300 -> duty, rev and busy are 0 asynchronously; after release, no motion until cmd_vld.
